// File: rtl/fp_fetch_pkg.sv
// Shared types and constants for the operand fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_fetch_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDRESS_WIDTH = 7;

    // All-ones is the ROM's reset/unwritten value; sliced to DATA_WIDTH at use.
    localparam logic [63:0] SENTINEL = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_A    = 3'd1,
        RD_B    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/operand_fetch.sv
// Walks the operand ROM two words at a time and presents (A, B) pairs downstream.
// Latency: first op_valid 3 cycles after start; 3 cycles per pair with op_ready high.
// Backpressure: PRESENT holds op_a/op_b/op_index and op_valid until op_ready; no ROM reads meanwhile.
// Optional: define FETCH_SENTINEL_EN to end a run early when operand A reads back all-ones.
module operand_fetch
    import fp_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_PAIRS     = 64,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic                     rom_ren,
    output logic                     rom_cen,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    op_a,
    output logic [DATA_WIDTH-1:0]    op_b,
    output logic [ADDRESS_WIDTH-1:0] op_index,
    output logic                     op_valid,
    input  logic                     op_ready
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE       = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(NUM_PAIRS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE        = ADDRESS_WIDTH'(1);

    fetch_state_t             state;
    fetch_state_t             next_state;
    logic [ADDRESS_WIDTH-1:0] pointer;
    logic [ADDRESS_WIDTH-1:0] index;
    logic                     last_pair;

    assign last_pair = (index == LAST_INDEX);

`ifdef FETCH_SENTINEL_EN
    logic a_is_sentinel;
    assign a_is_sentinel = (rom_data == SENTINEL[DATA_WIDTH-1:0]);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RD_A;
`ifdef FETCH_SENTINEL_EN
            RD_A:    next_state = a_is_sentinel ? DONE : RD_B;
`else
            RD_A:    next_state = RD_B;
`endif
            RD_B:    next_state = PRESENT;
            PRESENT: if (op_ready) next_state = last_pair ? DONE : RD_A;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status and strobe outputs decoded straight from the state.
    always_comb begin
        rom_ren  = (state == RD_A) || (state == RD_B);
        rom_cen  = (state == RD_A) || (state == RD_B);
        busy     = (state == RD_A) || (state == RD_B) || (state == PRESENT);
        done     = (state == DONE);
        op_valid = (state == PRESENT);
    end

    // Pointer, pair counter and operand capture; ROM data lands one cycle after issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer  <= BASE;
            index    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pointer <= BASE;
                        index   <= '0;
                    end
                end
                RD_A: begin
                    op_a    <= rom_data;
                    pointer <= pointer + ONE;
                end
                RD_B: begin
                    op_b     <= rom_data;
                    pointer  <= pointer + ONE;
                    // op_index only moves when a pair is about to be shown, so an
                    // early-terminated run leaves it on the last presented pair.
                    op_index <= index;
                end
                PRESENT: begin
                    if (op_ready && !last_pair) index <= index + ONE;
                end
                default: ;
            endcase
        end
    end

    // ROM address is loaded ahead of each read state and otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
        end else if (next_state == RD_A) begin
            rom_address <= (state == IDLE) ? BASE : pointer;
        end else if (next_state == RD_B) begin
            rom_address <= pointer + ONE;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: two instances (base 0 / 4 pairs, base 126 / 2 pairs).
// Latency: n/a.
// Backpressure: op_ready driven randomly or held low to stall PRESENT.
module tb_operand_fetch;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int NP0   = 4;
    localparam int NP1   = 2;
    localparam int BASE1 = 126;

    typedef struct packed {
        int            c;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] idx;
    } acc_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start0, op_ready0, busy0, done0, ren0, cen0, valid0;
    logic [AW-1:0] addr0, index0;
    logic [DW-1:0] rdata0, a0, b0;
    logic          start1, op_ready1, busy1, done1, ren1, cen1, valid1;
    logic [AW-1:0] addr1, index1;
    logic [DW-1:0] rdata1, a1, b1;

    logic [DW-1:0] mem [0:127];

    operand_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PAIRS(NP0), .BASE_ADDR(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .rom_address(addr0), .rom_ren(ren0), .rom_cen(cen0), .rom_data(rdata0),
        .op_a(a0), .op_b(b0), .op_index(index0), .op_valid(valid0), .op_ready(op_ready0));

    operand_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PAIRS(NP1), .BASE_ADDR(BASE1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .rom_address(addr1), .rom_ren(ren1), .rom_cen(cen1), .rom_data(rdata1),
        .op_a(a1), .op_b(b1), .op_index(index1), .op_valid(valid1), .op_ready(op_ready1));

    // ROM model: samples address on the falling edge of the issuing cycle.
    always @(negedge clk) begin
        if (ren0 && cen0) rdata0 <= mem[addr0];
        if (ren1 && cen1) rdata1 <= mem[addr1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    acc_t          acc0_q[$];
    acc_t          acc1_q[$];
    acc_t          exp_q[$];
    int            done0_q[$];
    int            done1_q[$];
    logic [AW-1:0] addr0_q[$];
    logic [AW-1:0] addr1_q[$];
    int            stall_err = 0;
    int            ren_valid_err = 0;
    bit            prev_hold = 1'b0;
    logic [38:0]   prev_pair;
    int            n_checks = 0;
    int            n_fail = 0;
    int            start_cyc;

    // Observer: logs issued addresses, accepted pairs, done pulses and hold violations.
    always @(negedge clk) begin
        if (ren0) addr0_q.push_back(addr0);
        if (ren1) addr1_q.push_back(addr1);
        if (valid0 && ren0) ren_valid_err++;
        if (prev_hold && !reset && (!valid0 || {a0, b0, index0} !== prev_pair)) stall_err++;
        prev_hold = valid0 && !op_ready0 && !reset;
        prev_pair = {a0, b0, index0};
        if (valid0 && op_ready0) acc0_q.push_back('{c: cyc, a: a0, b: b0, idx: index0});
        if (valid1 && op_ready1) acc1_q.push_back('{c: cyc, a: a1, b: b1, idx: index1});
        if (done0) done0_q.push_back(cyc);
        if (done1) done1_q.push_back(cyc);
    end

    // Reference: pair k is (mem[base+2k], mem[base+2k+1]) modulo ROM size.
    task automatic build_exp(input int base, input int np);
        exp_q.delete();
        for (int k = 0; k < np; k++) begin
            acc_t e;
            e.c   = 0;
            e.a   = mem[(base + 2 * k) % 128];
            e.b   = mem[(base + 2 * k + 1) % 128];
            e.idx = AW'(k);
`ifdef FETCH_SENTINEL_EN
            if (e.a == 16'hFFFF) break;
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) mem[i] = DW'($urandom_range(0, 16'hFFFE));
    endtask

    // Runs u0 to completion; mode 0 ready high, 1 random ready, 2 stall pair 1 for 5 cycles.
    task automatic run0(input int mode, output bit ok);
        int low_left;
        low_left = 5;
        ok = 1'b0;
        acc0_q.delete(); done0_q.delete(); addr0_q.delete();
        op_ready0 = (mode != 1);
        @(posedge clk); #1 start0 = 1'b1; start_cyc = cyc;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 start0 = 1'b0;
            if (done0) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            case (mode)
                1: op_ready0 = 1'($urandom_range(0, 1));
                2: begin
                    if (valid0 && index0 == 1 && low_left > 0) begin
                        op_ready0 = 1'b0;
                        low_left--;
                    end else begin
                        op_ready0 = 1'b1;
                    end
                end
                default: op_ready0 = 1'b1;
            endcase
        end
        op_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_pairs0(input string name);
        n_checks++;
        if (acc0_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d pairs, expected %0d", name, acc0_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if ({acc0_q[k].a, acc0_q[k].b, acc0_q[k].idx} !== {exp_q[k].a, exp_q[k].b, exp_q[k].idx}) begin
                    n_fail++;
                    $display("FAIL %s_pair%0d: got a=%h b=%h idx=%0d, expected a=%h b=%h idx=%0d", name, k,
                             acc0_q[k].a, acc0_q[k].b, acc0_q[k].idx, exp_q[k].a, exp_q[k].b, exp_q[k].idx);
                end
            end
        end
        n_checks++;
        if (done0_q.size() != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d, expected 1", name, done0_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy0, done0, addr0, ren0, cen0, a0, b0, index0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", {busy0, done0, addr0, ren0, cen0, a0, b0, index0, valid0});
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_first_pair();
        bit ok;
        fill_mem();
        mem[0] = 16'h3C00;
        mem[1] = 16'h4000;
        build_exp(0, NP0);
        run0(0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL first_done_timeout: got no done, expected done"); end
        n_checks++;
        if (acc0_q.size() == 0 || acc0_q[0].c != start_cyc + 3) begin
            n_fail++;
            $display("FAIL first_latency: got cycle %0d, expected %0d",
                     acc0_q.size() ? acc0_q[0].c : -1, start_cyc + 3);
        end
        compare_pairs0("first");
        n_checks++;
        if (acc0_q.size() == NP0 && done0_q.size() == 1 && done0_q[0] != acc0_q[NP0-1].c + 1) begin
            n_fail++;
            $display("FAIL done_timing: got cycle %0d, expected %0d", done0_q[0], acc0_q[NP0-1].c + 1);
        end
        n_checks++;
        if (addr0_q.size() != 2 * NP0 || addr0_q[0] !== 7'd0 || addr0_q[2 * NP0 - 1] !== 7'(2 * NP0 - 1)) begin
            n_fail++;
            $display("FAIL first_addresses: got %0d reads, expected %0d from 0", addr0_q.size(), 2 * NP0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        fill_mem();
        build_exp(0, NP0);
        run0(2, ok);
        compare_pairs0("stall");
        n_checks++;
        if (acc0_q.size() >= 2 && acc0_q[1].c - acc0_q[0].c != 8) begin
            n_fail++;
            $display("FAIL stall_gap: got %0d cycles, expected 8", acc0_q[1].c - acc0_q[0].c);
        end
        n_checks++;
        if (stall_err != 0 || ren_valid_err != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d hold and %0d ren errors, expected 0", stall_err, ren_valid_err);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            fill_mem();
            build_exp(0, NP0);
            run0(1, ok);
            compare_pairs0("random");
        end
        n_checks++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL random_hold: got %0d errors, expected 0", stall_err);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ok = 1'b0;
        fill_mem();
        acc1_q.delete(); done1_q.delete(); addr1_q.delete();
        op_ready1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (done1) ok = 1'b1;
        end
        n_checks++;
        if (!ok || addr1_q.size() != 4 || {addr1_q[0], addr1_q[1], addr1_q[2], addr1_q[3]} !== {7'd126, 7'd127, 7'd0, 7'd1}) begin
            n_fail++;
            $display("FAIL wrap_addresses: got %0d reads (done=%0d), expected 126,127,0,1", addr1_q.size(), ok);
        end
        n_checks++;
        if (acc1_q.size() != 2 || {acc1_q[1].a, acc1_q[1].b, acc1_q[1].idx} !== {mem[0], mem[1], 7'd1}) begin
            n_fail++;
            $display("FAIL wrap_pair1: got %0d pairs, expected a=%h b=%h idx=1", acc1_q.size(), mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit hit;
        hit = 1'b0;
        fill_mem();
        op_ready0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b1;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1 start0 = 1'b0;
            if (ren0 && addr0 == 7'd5) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL midrun_reach: got no RD_B of pair 2, expected one"); end
        done0_q.delete();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy0, done0, addr0, ren0, cen0, a0, b0, index0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %h, expected 0", {busy0, done0, addr0, ren0, cen0, a0, b0, index0, valid0});
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done0_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d pulses, expected 0", done0_q.size());
        end
        build_exp(0, NP0);
        run0(0, ok);
        compare_pairs0("restart");
        n_checks++;
        if (addr0_q.size() == 0 || addr0_q[0] !== 7'd0) begin
            n_fail++;
            $display("FAIL restart_base: got %0d, expected 0", addr0_q.size() ? addr0_q[0] : 7'h7F);
        end
    endtask

    task automatic test_start_in_present();
        bit ok;
        logic [38:0] held;
        ok = 1'b0;
        fill_mem();
        build_exp(0, NP0);
        acc0_q.delete(); done0_q.delete(); addr0_q.delete();
        op_ready0 = 1'b0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int i = 0; i < 10 && !valid0; i++) begin
            @(posedge clk); #1;
        end
        held = {a0, b0, index0};
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (!valid0 || {a0, b0, index0} !== held || held !== {exp_q[0].a, exp_q[0].b, exp_q[0].idx}) begin
            n_fail++;
            $display("FAIL start_in_present_hold: got valid=%0d pair=%h, expected valid=1 pair=%h",
                     valid0, {a0, b0, index0}, {exp_q[0].a, exp_q[0].b, exp_q[0].idx});
        end
        op_ready0 = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (done0) ok = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        compare_pairs0("start_in_present");
        n_checks++;
        if (addr0_q.size() != 2 * NP0) begin
            n_fail++;
            $display("FAIL start_in_present_reads: got %0d, expected %0d", addr0_q.size(), 2 * NP0);
        end
    endtask

    task automatic test_sentinel();
        bit ok;
        fill_mem();
        mem[4] = 16'hFFFF;
        build_exp(0, NP0);
        run0(0, ok);
        compare_pairs0("sentinel");
        n_checks++;
        if (index0 !== exp_q[exp_q.size() - 1].idx) begin
            n_fail++;
            $display("FAIL sentinel_last_index: got %0d, expected %0d", index0, exp_q[exp_q.size() - 1].idx);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start0    = 1'b0;
        start1    = 1'b0;
        op_ready0 = 1'b1;
        op_ready1 = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_first_pair();
        test_backpressure();
        test_random_ready();
        test_wrap();
        test_reset_mid_run();
        test_start_in_present();
        test_sentinel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
